// File: rtl/input_event_arbiter.sv
// Two-player button event arbiter: rising-edge press detection per player,
// a small event FIFO per player, and a round-robin output stage that
// presents one event at a time on a valid/ready handshake.
module input_event_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] c1,
  input  logic [9:0] c2,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       ev_player,
  output logic [3:0] ev_button,
  output logic [1:0] ovf,
  input  logic       ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {EMPTY, HOLD} out_state_t;

  out_state_t state, next_state;

  logic [9:0]    prev      [2];
  logic [9:0]    cur       [2];
  logic [9:0]    new_bits  [2];
  logic [3:0]    press_idx [2];
  logic [3:0]    mem       [2][FIFO_DEPTH];
  logic [AW-1:0] rd_ptr    [2];
  logic [AW-1:0] wr_ptr    [2];
  logic [AW:0]   count     [2];

  logic [1:0] press, not_empty, full, pop, push, drop;
  logic       load, grant, last_grant;

  // Lowest set bit wins when several buttons rise together.
  function automatic logic [3:0] lowest_index(input logic [9:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 9; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Per-player press detection and FIFO status.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cur[0] = c1;
    cur[1] = c2;
    press     = '0;
    not_empty = '0;
    full      = '0;
    for (int p = 0; p < 2; p++) begin
      new_bits[p]  = cur[p] & ~prev[p];
      press[p]     = |new_bits[p];
      press_idx[p] = lowest_index(new_bits[p]);
      not_empty[p] = (count[p] != '0);
      full[p]      = (count[p] == CNT_FULL);
    end
  end

  // Output-stage next state, arbitration and FIFO push/pop decisions.
  always_comb begin
    next_state = state;
    load       = (state == EMPTY) || ev_ready;
    grant      = (&not_empty) ? ~last_grant : not_empty[1];
    pop        = '0;
    if (load) begin
      if (|not_empty) begin
        pop[grant] = 1'b1;
        next_state = HOLD;
      end else begin
        next_state = EMPTY;
      end
    end
    push = press & (~full | pop);
    drop = press & full & ~pop;
  end

  assign ev_valid = (state == HOLD);

  // Output-stage state register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= EMPTY;
    else       state <= next_state;
  end

  // FIFO storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clock) begin
    // NOTE: the memory array is deliberately not reset; stale entries are never visible past count.
    for (int p = 0; p < 2; p++) begin
      if (push[p]) mem[p][wr_ptr[p]] <= press_idx[p];
    end
  end

  // Pointers, counts, previous-button vectors, presented event and flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        prev[p]   <= '0;
        rd_ptr[p] <= '0;
        wr_ptr[p] <= '0;
        count[p]  <= '0;
      end
      last_grant <= 1'b1;
      ev_player  <= 1'b0;
      ev_button  <= '0;
      ovf        <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        prev[p] <= cur[p];
        if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
        if (pop[p])  rd_ptr[p] <= rd_ptr[p] + 1'b1;
        count[p] <= count[p] + (AW+1)'(push[p]) - (AW+1)'(pop[p]);
      end
      if (|pop) begin
        ev_player  <= grant;
        ev_button  <= mem[grant][rd_ptr[grant]];
        last_grant <= grant;
      end
      ovf <= ovf_clr ? drop : (ovf | drop);
    end
  end

endmodule
